alu_cmd_sequencer: RTL

//  Command front-end for the matrix alu: accepts one matrix command on a valid/ready handshake and registers its operands.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/matrix_size_mask.sv | 21 ++
 rtl/alu_cmd_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, widths, error codes and sequencer state encoding for the matrix alu front-end.
package alu_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b011;
    localparam logic [2:0] OP_OPP    = 3'b100;
    localparam logic [2:0] OP_TRANS  = 3'b101;
    localparam logic [2:0] OP_SCALAR = 3'b110;
    localparam logic [2:0] OP_DET    = 3'b111;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned MAX_N  = 5;
    localparam int unsigned MAT_W  = ELEM_W * MAX_N * MAX_N;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_CMD = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_size_mask.sv
// Zeroes every element of a MAX_N x MAX_N byte matrix whose row or column lies at or beyond n.
module matrix_size_mask
    import alu_pkg::*;
(
    input  logic [2:0]       size,
    input  logic [MAT_W-1:0] matrix_in,
    output logic [MAT_W-1:0] matrix_out
);

    always_comb begin
        matrix_out = '0;
        for (int unsigned r = 0; r < MAX_N; r++) begin
            for (int unsigned c = 0; c < MAX_N; c++) begin
                if (r < 32'(size) && c < 32'(size)) begin
                    matrix_out[(r*MAX_N+c)*ELEM_W +: ELEM_W] = matrix_in[(r*MAX_N+c)*ELEM_W +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the matrix alu: one command in, one alu operation, one registered response out.
// Optional determinant abort on a stuck alu is enabled with `define ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [2:0]       cmd_size,
    input  logic [7:0]       cmd_scalar,
    input  logic [MAT_W-1:0] cmd_a,
    input  logic [MAT_W-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MAT_W-1:0] rsp_matrix,
    output logic [7:0]       rsp_number,
    output logic             rsp_overflow,
    output logic [1:0]       rsp_error,
    output logic             busy,
    output logic [MAT_W-1:0] alu_A_flat,
    output logic [MAT_W-1:0] alu_B_flat,
    output logic [7:0]       alu_scalar,
    output logic [2:0]       alu_matrix_size,
    output logic [2:0]       alu_opcode,
    input  logic [MAT_W-1:0] alu_C_flat,
    input  logic [7:0]       alu_number,
    input  logic             alu_overflow,
    input  logic             alu_done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic             cmd_legal;
    logic             accept, cap_res, cap_det, cap_tmo;
    logic [MAT_W-1:0] c_masked;

    assign cmd_legal = (cmd_opcode != OP_NOP) && (cmd_size >= 3'd2) && (cmd_size <= 3'd5);
    assign busy      = (state_q != IDLE);

    matrix_size_mask u_mask (
        .size       (alu_matrix_size),
        .matrix_in  (alu_C_flat),
        .matrix_out (c_masked)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        cap_res    = 1'b0;
        cap_det    = 1'b0;
        cap_tmo    = 1'b0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_opcode = OP_NOP;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = cmd_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                alu_opcode = op_q;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (op_q == OP_DET) begin
                    // done seen in the first EXEC cycle belongs to the previous determinant
                    if (alu_done && cnt_q != '0) begin
                        cap_det = 1'b1;
                        state_d = RESP;
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cap_tmo = 1'b1;
                        state_d = RESP;
                    end
`endif
                end else if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
                    cap_res = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q            <= OP_NOP;
            alu_matrix_size <= '0;
            alu_scalar      <= '0;
            alu_A_flat      <= '0;
            alu_B_flat      <= '0;
            rsp_matrix      <= '0;
            rsp_number      <= '0;
            rsp_overflow    <= 1'b0;
            rsp_error       <= ERR_OK;
        end else begin
            if (accept) begin
                op_q            <= cmd_opcode;
                alu_matrix_size <= cmd_size;
                alu_scalar      <= cmd_scalar;
                alu_A_flat      <= cmd_a;
                alu_B_flat      <= cmd_b;
                if (!cmd_legal) begin
                    rsp_matrix   <= '0;
                    rsp_number   <= '0;
                    rsp_overflow <= 1'b0;
                    rsp_error    <= ERR_CMD;
                end
            end
            if (cap_res) begin
                rsp_matrix   <= c_masked;
                rsp_number   <= '0;
                rsp_overflow <= alu_overflow && (op_q != OP_OPP) && (op_q != OP_TRANS);
                rsp_error    <= ERR_OK;
            end
            if (cap_det) begin
                rsp_matrix   <= '0;
                rsp_number   <= alu_number;
                rsp_overflow <= alu_overflow;
                rsp_error    <= ERR_OK;
            end
            if (cap_tmo) begin
                rsp_matrix   <= '0;
                rsp_number   <= '0;
                rsp_overflow <= 1'b0;
                rsp_error    <= ERR_TMO;
            end
        end
    end

endmodule
